en_sequencer: RTL and testbench

Sequences the per-bit enables of a clock-gated register bank so that a serial data stream is written into a programmable subset of bit positions, one bit per accepted beat. It sits between an upstream serial producer (valid/ready) and a bank of independently enabled flops. It drives one-hot registered enables, so at most one flop's gate opens per cycle and gating logic sees clean, glitch-free enables.

---
 rtl/en_sequencer_pkg.sv | 18 +
 rtl/en_sequencer_pick.sv | 38 +++
 rtl/en_sequencer.sv | 128 ++++++++++++
 tb/tb_en_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/en_sequencer_pkg.sv
// Shared definitions for the enable sequencer.
//   state_t   : FSM encoding (IDLE, RUN, FIN)
//   N_DEFAULT : default number of enable lines
//   LSB_FIRST / MSB_FIRST : walk order selected by DIR
package en_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned N_DEFAULT = 5;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/en_sequencer_pick.sv
// first_set_pick: combinational priority picker.
//   VEC   in  N   candidate bit vector
//   DIR   in  1   LSB_FIRST picks the lowest set bit, MSB_FIRST the highest
//   IDX   out IW  index of the picked bit ('0 when nothing is set)
//   VALID out 1   at least one bit of VEC is set
module first_set_pick
  import en_sequencer_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  VEC,
  input  logic          DIR,
  output logic [IW-1:0] IDX,
  output logic          VALID
);

  always_comb begin
    IDX   = '0;
    VALID = 1'b0;
    if (DIR == MSB_FIRST) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!VALID && VEC[N-1-k]) begin
          IDX   = IW'(N - 1 - k);
          VALID = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!VALID && VEC[k]) begin
          IDX   = IW'(k);
          VALID = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/en_sequencer.sv
// en_sequencer: writes a serial valid/ready stream into a programmable set of
// bit positions of a clock-gated register bank, one bit per accepted beat.
//   CLK, RST          clock, synchronous active-high reset
//   START, MASK, DIR  sequence request, positions to write, walk order (IDLE only)
//   ABORT             cancel a running sequence
//   D_VALID, D_IN     upstream beat
//   D_READY           beat can be accepted this cycle
//   EN, D_OUT         registered one-hot enable and data to the bank
//   BUSY, DONE        sequence in progress, one-cycle completion pulse
module en_sequencer
  import en_sequencer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] MASK,
  input  logic         DIR,
  input  logic         ABORT,
  input  logic         D_VALID,
  input  logic         D_IN,
  output logic         D_READY,
  output logic [N-1:0] EN,
  output logic         D_OUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  state_t        state, state_d;
  logic [N-1:0]  pend, pend_d;
  logic [IW-1:0] ptr, ptr_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  en_q, en_d;
  logic          dout_q, dout_d;

  logic [N-1:0]  ptr_oh;
  logic [N-1:0]  pick_vec;
  logic          pick_dir;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  // One picker serves both cases: in IDLE it looks at the incoming MASK,
  // in RUN at the pending set with the bit being written already removed.
  always_comb begin
    ptr_oh      = '0;
    ptr_oh[ptr] = 1'b1;
    if (state == IDLE) begin
      pick_vec = MASK;
      pick_dir = DIR;
    end else begin
      pick_vec = pend & ~ptr_oh;
      pick_dir = dir_q;
    end
  end

  first_set_pick #(.N(N), .IW(IW)) u_pick (
    .VEC   (pick_vec),
    .DIR   (pick_dir),
    .IDX   (pick_idx),
    .VALID (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      pend   <= '0;
      ptr    <= '0;
      dir_q  <= LSB_FIRST;
      en_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      state  <= state_d;
      pend   <= pend_d;
      ptr    <= ptr_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      dout_q <= dout_d;
    end
  end

  always_comb begin
    state_d = state;
    pend_d  = pend;
    ptr_d   = ptr;
    dir_d   = dir_q;
    en_d    = '0;
    dout_d  = dout_q;
    case (state)
      IDLE: begin
        if (START) begin
          pend_d  = MASK;
          dir_d   = DIR;
          ptr_d   = pick_idx;
          state_d = pick_valid ? RUN : FIN;
        end
      end
      RUN: begin
        // ABORT takes priority so a same-cycle beat is never written.
        if (ABORT) begin
          pend_d  = '0;
          state_d = IDLE;
        end else if (D_VALID) begin
          en_d    = ptr_oh;
          dout_d  = D_IN;
          pend_d  = pick_vec;
          ptr_d   = pick_idx;
          state_d = pick_valid ? RUN : FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign D_READY = (state == RUN);
  assign BUSY    = (state != IDLE);
  assign DONE    = (state == FIN);
  assign EN      = en_q;
  assign D_OUT   = dout_q;

endmodule

// File: tb/tb_en_sequencer.sv
module tb_en_sequencer;

  logic       CLK = 1'b0;
  logic       RST, START, DIR, ABORT, D_VALID, D_IN;
  logic [4:0] MASK;
  logic       D_READY, D_OUT, BUSY, DONE;
  logic [4:0] EN;

  int tests  = 0;
  int failed = 0;

  en_sequencer #(.N(5)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .MASK    (MASK),
    .DIR     (DIR),
    .ABORT   (ABORT),
    .D_VALID (D_VALID),
    .D_IN    (D_IN),
    .D_READY (D_READY),
    .EN      (EN),
    .D_OUT   (D_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, start;
    logic [4:0] mask;
    logic       dir, abort, valid, din;
    logic [4:0] en;
    logic       dout, rdy, busy, done;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic rst, logic start, logic [4:0] mask, logic dir,
                              logic abort, logic valid, logic din, logic [4:0] en,
                              logic dout, logic rdy, logic busy, logic done);
    vec_t v;
    v.rst = rst; v.start = start; v.mask = mask; v.dir = dir; v.abort = abort;
    v.valid = valid; v.din = din; v.en = en; v.dout = dout; v.rdy = rdy;
    v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic start, input logic [4:0] mask,
                       input logic dir, input logic abort, input logic valid, input logic din);
    RST = rst; START = start; MASK = mask; DIR = dir; ABORT = abort;
    D_VALID = valid; D_IN = din;
  endtask

  // Advance one clock and sample just after the edge; EN must never be multi-hot.
  task automatic step();
    @(posedge CLK);
    #1;
    check("en_onehot", 32'($countones(EN) <= 1), 32'd1);
  endtask

  int pulses;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    //              rst  st  mask      dir  ab  vl  din   en        do  rdy bsy dn
    tbl[0]  = mk(1'b1,1'b0,5'b00000,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b0,1'b0,1'b0,1'b0);
    // LSB-first over 10110, data 1,0,1
    tbl[1]  = mk(1'b0,1'b1,5'b10110,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b0,1'b1,1'b1,1'b0);
    tbl[2]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b00010,1'b1,1'b1,1'b1,1'b0);
    tbl[3]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b00100,1'b0,1'b1,1'b1,1'b0);
    tbl[4]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b10000,1'b1,1'b0,1'b1,1'b1);
    tbl[5]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b00000,1'b1,1'b0,1'b0,1'b0);
    // MSB-first over the same mask, data 0,1,1
    tbl[6]  = mk(1'b0,1'b1,5'b10110,1'b1,1'b0,1'b0,1'b0, 5'b00000,1'b1,1'b1,1'b1,1'b0);
    tbl[7]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b10000,1'b0,1'b1,1'b1,1'b0);
    tbl[8]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b00100,1'b1,1'b1,1'b1,1'b0);
    tbl[9]  = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b00010,1'b1,1'b0,1'b1,1'b1);
    tbl[10] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b1,1'b0,1'b0,1'b0);
    // empty mask: straight to FIN
    tbl[11] = mk(1'b0,1'b1,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b00000,1'b1,1'b0,1'b1,1'b1);
    tbl[12] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b00000,1'b1,1'b0,1'b0,1'b0);
    // abort together with the 2nd accept
    tbl[13] = mk(1'b0,1'b1,5'b01111,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b1,1'b1,1'b1,1'b0);
    tbl[14] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b0, 5'b00001,1'b0,1'b1,1'b1,1'b0);
    tbl[15] = mk(1'b0,1'b0,5'b00000,1'b0,1'b1,1'b1,1'b1, 5'b00000,1'b0,1'b0,1'b0,1'b0);
    tbl[16] = mk(1'b0,1'b1,5'b00001,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b0,1'b1,1'b1,1'b0);
    tbl[17] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b00001,1'b1,1'b0,1'b1,1'b1);
    tbl[18] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b1,1'b0,1'b0,1'b0);
    // START mid-run ignored; START and ABORT during FIN ignored
    tbl[19] = mk(1'b0,1'b1,5'b00001,1'b0,1'b0,1'b0,1'b0, 5'b00000,1'b1,1'b1,1'b1,1'b0);
    tbl[20] = mk(1'b0,1'b1,5'b11111,1'b0,1'b0,1'b1,1'b0, 5'b00001,1'b0,1'b0,1'b1,1'b1);
    tbl[21] = mk(1'b0,1'b1,5'b00011,1'b0,1'b1,1'b1,1'b1, 5'b00000,1'b0,1'b0,1'b0,1'b0);
    tbl[22] = mk(1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1,1'b1, 5'b00000,1'b0,1'b0,1'b0,1'b0);

    @(negedge CLK);
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].mask, tbl[i].dir, tbl[i].abort,
            tbl[i].valid, tbl[i].din);
      step();
      check($sformatf("row%0d_en", i),    32'(EN),      32'(tbl[i].en));
      check($sformatf("row%0d_dout", i),  32'(D_OUT),   32'(tbl[i].dout));
      check($sformatf("row%0d_ready", i), 32'(D_READY), 32'(tbl[i].rdy));
      check($sformatf("row%0d_busy", i),  32'(BUSY),    32'(tbl[i].busy));
      check($sformatf("row%0d_done", i),  32'(DONE),    32'(tbl[i].done));
    end

    // Full mask with D_VALID toggling: an EN pulse only after each accept.
    drive(1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("tog_ready", 32'(D_READY), 32'd1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      logic [4:0] exp_en;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, (k % 2 == 0), k[1]);
      step();
      exp_en = (k % 2 == 0) ? 5'(1 << (k / 2)) : 5'b00000;
      if (EN != 0) pulses++;
      check($sformatf("tog%0d_en", k),   32'(EN),   32'(exp_en));
      check($sformatf("tog%0d_done", k), 32'(DONE), 32'(k == 8));
      if (k % 2 == 0)
        check($sformatf("tog%0d_dout", k), 32'(D_OUT), 32'(k[1]));
    end
    check("tog_pulses", 32'(pulses), 32'd5);
    check("tog_busy_after", 32'(BUSY), 32'd0);

    // START with a different mask during RUN must not change the sequence.
    drive(1'b0, 1'b1, 5'b00101, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    pulses = 0;
    begin
      int cyc;
      cyc = 0;
      drive(1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b1);
      while (!DONE && cyc < 20) begin
        step();
        if (EN != 0) pulses++;
        if (pulses == 1) check("ign_first_en", 32'(EN), 32'(5'b00100));
        cyc++;
      end
      check("ign_done_seen", 32'(DONE), 32'd1);
      check("ign_last_en", 32'(EN), 32'(5'b00001));
      check("ign_pulses", 32'(pulses), 32'd2);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("ign_idle_busy", 32'(BUSY), 32'd0);

    // Reset in the middle of a full-mask sequence after two writes.
    drive(1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("rst_w1_en", 32'(EN), 32'(5'b00001));
    step();
    check("rst_w2_en", 32'(EN), 32'(5'b00010));
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("rst_en",    32'(EN),      32'd0);
    check("rst_dout",  32'(D_OUT),   32'd0);
    check("rst_ready", 32'(D_READY), 32'd0);
    check("rst_busy",  32'(BUSY),    32'd0);
    check("rst_done",  32'(DONE),    32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("rst_stay_idle_en",   32'(EN),   32'd0);
    check("rst_stay_idle_busy", 32'(BUSY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
